// File: rtl/pc_gen_if.sv
// Fetch-stage redirect/control bundle between the pipeline control logic
// (master) and the program-counter generator (slave).
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            exception;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            ret;
   logic            jump;
   logic [XLEN-1:0] jump_target;
   logic            call;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic            ras_empty;
   logic            ras_full;
   logic            misalign_err;

   modport master (
      output stall, exception, branch_taken, branch_target,
             ret, jump, jump_target, call,
      input  pc, pc_next, ras_empty, ras_full, misalign_err
   );

   modport slave (
      input  stall, exception, branch_taken, branch_target,
             ret, jump, jump_target, call,
      output pc, pc_next, ras_empty, ras_full, misalign_err
   );
endinterface

// File: rtl/pc_gen.sv
// Registered program-counter generator with fixed-priority redirect
// selection, stall handling and a circular return-address stack.
module pc_gen #(
   parameter int              XLEN       = 32,
   parameter int              INST_BYTES = 4,
   parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] EXC_VEC    = 32'h0000_0180,
   parameter int              RAS_DEPTH  = 4
) (
   input logic   clk,
   input logic   rst_n,
   pc_gen_if.slave bus
);
   localparam int              PTR_W      = $clog2(RAS_DEPTH);
   localparam int              CNT_W      = $clog2(RAS_DEPTH + 1);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

   logic [XLEN-1:0]  pc_reg;
   logic [XLEN-1:0]  pc_sel;
   logic [XLEN-1:0]  pc_seq;
   logic             misalign_reg;
   logic             misalign_next;

   // ptr_reg is the next slot to write; the top of stack sits one below it.
   logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] top_idx;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             ras_nonempty;
   logic             ret_wins;
   logic             do_pop;
   logic             do_push;
   logic             ras_wr_en;
   logic [PTR_W-1:0] ras_wr_idx;
   logic             is_redirect;

   assign pc_seq       = pc_reg + XLEN'(INST_BYTES);
   assign top_idx      = ptr_reg - PTR_W'(1);
   assign ras_nonempty = (cnt_reg != '0);
   assign do_pop       = ret_wins && ras_nonempty;
   assign do_push      = bus.call && !bus.stall && !bus.exception;

   // Next-PC selection by fixed priority; stall freezes everything except an exception.
   always_comb begin
      pc_sel        = pc_reg;
      misalign_next = misalign_reg;
      ret_wins      = 1'b0;
      is_redirect   = 1'b0;
      if (bus.exception) begin
         pc_sel        = EXC_VEC;
         misalign_next = 1'b0;
      end else if (!bus.stall) begin
         if (bus.branch_taken) begin
            pc_sel      = bus.branch_target;
            is_redirect = 1'b1;
         end else if (bus.ret) begin
            ret_wins    = 1'b1;
            pc_sel      = ras_nonempty ? ras_mem[top_idx] : bus.jump_target;
            is_redirect = 1'b1;
         end else if (bus.jump) begin
            pc_sel      = bus.jump_target;
            is_redirect = 1'b1;
         end else begin
            pc_sel = pc_seq;
         end
         // Only computed targets can be misaligned; the sequential path keeps the flag.
         if (is_redirect) begin
            misalign_next = |(pc_sel & ALIGN_MASK);
         end
      end
   end

   // RAS bookkeeping: a simultaneous push and pop overwrites the old top in place.
   always_comb begin
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      ras_wr_en  = 1'b0;
      ras_wr_idx = ptr_reg;
      if (do_push && do_pop) begin
         ras_wr_en  = 1'b1;
         ras_wr_idx = top_idx;
      end else if (do_push) begin
         ras_wr_en  = 1'b1;
         ras_wr_idx = ptr_reg;
         ptr_next   = ptr_reg + PTR_W'(1);
         if (cnt_reg != CNT_FULL) begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end else if (do_pop) begin
         ptr_next = top_idx;
         cnt_next = cnt_reg - CNT_W'(1);
      end
   end

   // PC, RAS pointer/count and misalignment flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_VEC;
         ptr_reg      <= '0;
         cnt_reg      <= '0;
         misalign_reg <= 1'b0;
      end else begin
         pc_reg       <= pc_sel;
         ptr_reg      <= ptr_next;
         cnt_reg      <= cnt_next;
         misalign_reg <= misalign_next;
      end
   end

   // RAS storage; contents need no reset since the count guards every read.
   always_ff @(posedge clk) begin
      if (ras_wr_en) begin
         ras_mem[ras_wr_idx] <= pc_seq;
      end
   end

   assign bus.pc           = pc_reg;
   assign bus.pc_next      = pc_seq;
   assign bus.ras_empty    = (cnt_reg == '0);
   assign bus.ras_full     = (cnt_reg == CNT_FULL);
   assign bus.misalign_err = misalign_reg;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues hand-computed expectations
// per clock edge, the monitor pops and compares after each edge.
module tb_pc_gen;
   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        empty;
      logic        full;
      logic        mis;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb [$];

   pc_gen_if #(.XLEN(32)) bus ();

   pc_gen #(
      .XLEN(32), .INST_BYTES(4), .RESET_VEC(32'h0), .EXC_VEC(32'h180), .RAS_DEPTH(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
      end
   endtask

   // Monitor: after each edge, compare DUT outputs against the queued expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "pc", bus.pc, e.pc);
            chk(e.name, "pc_next", bus.pc_next, e.pc + 32'd4);
            chk(e.name, "ras_empty", {31'b0, bus.ras_empty}, {31'b0, e.empty});
            chk(e.name, "ras_full", {31'b0, bus.ras_full}, {31'b0, e.full});
            chk(e.name, "misalign", {31'b0, bus.misalign_err}, {31'b0, e.mis});
            $display("txn %-12s pc=%h empty=%b full=%b mis=%b", e.name, bus.pc,
                     bus.ras_empty, bus.ras_full, bus.misalign_err);
         end
      end
   end

   // One clock of stimulus; the expected post-edge state is queued before the edge.
   task automatic step(input string name, input logic st, input logic ex, input logic br,
                       input logic [31:0] bt, input logic rt, input logic jp,
                       input logic [31:0] jt, input logic cl, input logic [31:0] e_pc,
                       input logic e_em, input logic e_fu, input logic e_mi);
      exp_t e;
      bus.stall = st; bus.exception = ex; bus.branch_taken = br; bus.branch_target = bt;
      bus.ret = rt; bus.jump = jp; bus.jump_target = jt; bus.call = cl;
      e.name = name; e.pc = e_pc; e.empty = e_em; e.full = e_fu; e.mis = e_mi;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic jmp(input string name, input logic [31:0] t, input logic cl,
                      input logic e_em, input logic e_fu, input logic e_mi);
      step(name, 0, 0, 0, 0, 0, 1, t, cl, t, e_em, e_fu, e_mi);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      // reset state
      step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
      rst_n = 1'b1;
      step("seq1", 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
      step("seq2", 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 0);
      // branch beats jump
      jmp("to100", 32'h100, 0, 1, 0, 0);
      step("br_vs_jmp", 0, 0, 1, 32'h400, 0, 1, 32'h800, 0, 32'h400, 1, 0, 0);
      step("seq404", 0, 0, 0, 0, 0, 0, 0, 0, 32'h404, 1, 0, 0);
      // stall holds, exception overrides stall
      jmp("to20", 32'h20, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++)
         step("stall", 1, 0, 0, 0, 0, 1, 32'h80, 1, 32'h20, 1, 0, 0);
      step("exc_stall", 1, 1, 0, 0, 0, 0, 0, 1, 32'h180, 1, 0, 0);
      // call / return
      jmp("to10", 32'h10, 0, 1, 0, 0);
      jmp("call_jmp", 32'h200, 1, 0, 0, 0);
      step("ret1", 0, 0, 0, 0, 1, 0, 32'h500, 0, 32'h14, 1, 0, 0);
      step("ret_empty", 0, 0, 0, 0, 1, 0, 32'h300, 0, 32'h300, 1, 0, 0);
      // fill beyond depth, then drain
      jmp("to0", 32'h0, 0, 1, 0, 0);
      jmp("call_a", 32'h40, 1, 0, 0, 0);
      jmp("call_b", 32'h80, 1, 0, 0, 0);
      jmp("call_c", 32'hC0, 1, 0, 0, 0);
      jmp("call_d", 32'h100, 1, 0, 1, 0);
      step("call_e", 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 1, 0);
      step("pop_a", 0, 0, 0, 0, 1, 0, 32'h900, 0, 32'h104, 0, 0, 0);
      step("pop_b", 0, 0, 0, 0, 1, 0, 32'h900, 0, 32'hC4, 0, 0, 0);
      step("pop_c", 0, 0, 0, 0, 1, 0, 32'h900, 0, 32'h84, 0, 0, 0);
      step("pop_d", 0, 0, 0, 0, 1, 0, 32'h900, 0, 32'h44, 1, 0, 0);
      // call and ret together replace the top in place
      jmp("to600", 32'h600, 0, 1, 0, 0);
      step("call600", 0, 0, 0, 0, 0, 0, 0, 1, 32'h604, 0, 0, 0);
      step("call_ret", 0, 0, 0, 0, 1, 0, 32'h900, 1, 32'h604, 0, 0, 0);
      step("ret_repl", 0, 0, 0, 0, 1, 0, 32'h900, 0, 32'h608, 1, 0, 0);
      // branch preempts ret: no pop
      step("call608", 0, 0, 0, 0, 0, 0, 0, 1, 32'h60C, 0, 0, 0);
      step("br_vs_ret", 0, 0, 1, 32'h700, 1, 0, 32'h900, 0, 32'h700, 0, 0, 0);
      step("ret_after", 0, 0, 0, 0, 1, 0, 32'h900, 0, 32'h60C, 1, 0, 0);
      // alignment flag and wraparound
      jmp("mis202", 32'h202, 0, 1, 0, 1);
      step("seq206", 0, 0, 0, 0, 0, 0, 0, 0, 32'h206, 1, 0, 1);
      jmp("align300", 32'h300, 0, 1, 0, 0);
      jmp("toFFFC", 32'hFFFF_FFFC, 0, 1, 0, 0);
      step("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
      // reset mid-operation aborts a pending redirect and clears the flag
      jmp("mis_again", 32'h2, 0, 1, 0, 1);
      #2 rst_n = 1'b0;
      step("rst_abort", 0, 0, 0, 0, 0, 1, 32'h400, 1, 32'h0, 1, 0, 0);
      rst_n = 1'b1;
      step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
